// File: rtl/banco_movimenta_tiros_pkg.sv
// Shared definitions for the shot table: heading codes, FSM state codes and
// default table/grid dimensions.
package banco_movimenta_tiros_pkg;

    localparam int N_TIROS_PADRAO = 4;
    localparam int W_COORD_PADRAO = 4;

    localparam logic [1:0] DIR_CIMA     = 2'b00;
    localparam logic [1:0] DIR_DIREITA  = 2'b01;
    localparam logic [1:0] DIR_BAIXO    = 2'b10;
    localparam logic [1:0] DIR_ESQUERDA = 2'b11;

    typedef enum logic [4:0] {
        INICIO        = 5'd0,
        ESPERA        = 5'd1,
        VARRE         = 5'd2,
        FIM_MOVIMENTO = 5'd3,
        INSERE        = 5'd4
    } estado_t;

endpackage

// File: rtl/banco_movimenta_tiros_encontra_slot_livre.sv
// Priority encoder over the rendered bits: lowest-index free slot and a flag
// telling whether any slot is free at all.
module encontra_slot_livre #(
    parameter int N_TIROS = 4,
    parameter int W_IDX   = 2
) (
    input  logic [N_TIROS-1:0] renderizado,
    output logic [W_IDX-1:0]   indice_livre,
    output logic               tem_livre
);

    always_comb begin
        indice_livre = '0;
        tem_livre    = 1'b0;
        // Scanning downwards lets the lowest free index be the last one written.
        for (int i = N_TIROS - 1; i >= 0; i--) begin
            if (!renderizado[i]) begin
                indice_livre = W_IDX'(i);
                tem_livre    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/banco_movimenta_tiros.sv
// Active-shot table: holds shot positions/headings, advances rendered shots one
// cell per movement sweep and inserts pending fire requests into free slots.
//
// state         | meaning
// inicio        | post-reset, goes straight to espera
// espera        | idle; accepts a move tick or services a pending fire
// varre         | moves slot idx, one slot per cycle
// fim_movimento | one-cycle end-of-sweep pulse
// insere        | writes the latched shot into the lowest free slot
module banco_movimenta_tiros
    import banco_movimenta_tiros_pkg::*;
#(
    parameter int N_TIROS = N_TIROS_PADRAO,
    parameter int W_IDX   = 2,
    parameter int W_COORD = W_COORD_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dispara,
    input  logic [W_COORD-1:0] pos_nave_x,
    input  logic [W_COORD-1:0] pos_nave_y,
    input  logic [1:0]         direcao_nave,
    input  logic               move_tiros,
    input  logic               enable_load_tiro,
    input  logic               loaded_tiro,
    input  logic [W_IDX-1:0]   indice_escrita,
    input  logic [W_IDX-1:0]   indice_leitura,
    output logic [W_COORD-1:0] tiro_x,
    output logic [W_COORD-1:0] tiro_y,
    output logic               tiro_renderizado,
    output logic               ocupado,
    output logic               s_fim_movimento,
    output logic               tiro_descartado,
    output logic [4:0]         db_estado
);

    localparam logic [W_COORD-1:0] COORD_MAX  = '1;
    localparam logic [W_IDX-1:0]   IDX_ULTIMO = W_IDX'(N_TIROS - 1);

    estado_t estado, proximo;

    logic [W_COORD-1:0] pos_x [N_TIROS];
    logic [W_COORD-1:0] pos_y [N_TIROS];
    logic [1:0]         dir   [N_TIROS];
    logic [N_TIROS-1:0] renderizado;

    logic               pendente;
    logic [W_COORD-1:0] lat_x, lat_y;
    logic [1:0]         lat_dir;
    logic [W_IDX-1:0]   idx;

    logic [W_IDX-1:0]   indice_livre;
    logic               tem_livre;
    logic [W_COORD-1:0] prox_x, prox_y;
    logic               sai_grade;

    encontra_slot_livre #(
        .N_TIROS (N_TIROS),
        .W_IDX   (W_IDX)
    ) u_encontra_slot_livre (
        .renderizado  (renderizado),
        .indice_livre (indice_livre),
        .tem_livre    (tem_livre)
    );

    always_comb begin
        prox_x    = pos_x[idx];
        prox_y    = pos_y[idx];
        sai_grade = 1'b0;
        case (dir[idx])
            DIR_CIMA:     if (pos_y[idx] == '0)       sai_grade = 1'b1; else prox_y = pos_y[idx] - 1'b1;
            DIR_DIREITA:  if (pos_x[idx] == COORD_MAX) sai_grade = 1'b1; else prox_x = pos_x[idx] + 1'b1;
            DIR_BAIXO:    if (pos_y[idx] == COORD_MAX) sai_grade = 1'b1; else prox_y = pos_y[idx] + 1'b1;
            default:      if (pos_x[idx] == '0)       sai_grade = 1'b1; else prox_x = pos_x[idx] - 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIO;
        else        estado <= proximo;
    end

    always_comb begin
        proximo         = estado;
        s_fim_movimento = 1'b0;
        tiro_descartado = 1'b0;
        case (estado)
            INICIO: proximo = ESPERA;
            ESPERA: begin
                if (move_tiros)    proximo = VARRE;
                else if (pendente) proximo = INSERE;
            end
            VARRE: if (idx == IDX_ULTIMO) proximo = FIM_MOVIMENTO;
            FIM_MOVIMENTO: begin
                s_fim_movimento = 1'b1;
                proximo         = ESPERA;
            end
            INSERE: begin
                tiro_descartado = !tem_livre;
                proximo         = ESPERA;
            end
            default: proximo = INICIO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TIROS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                dir[i]   <= '0;
            end
            renderizado <= '0;
            pendente    <= 1'b0;
            lat_x       <= '0;
            lat_y       <= '0;
            lat_dir     <= '0;
            idx         <= '0;
        end else begin
            if (estado == ESPERA && move_tiros) idx <= '0;
            else if (estado == VARRE)           idx <= idx + 1'b1;

            // A fresh request arriving while the previous one is serviced stays pending.
            if (dispara) begin
                pendente <= 1'b1;
                lat_x    <= pos_nave_x;
                lat_y    <= pos_nave_y;
                lat_dir  <= direcao_nave;
            end else if (estado == INSERE) begin
                pendente <= 1'b0;
            end

            if (estado == VARRE && renderizado[idx]) begin
                if (sai_grade) begin
                    renderizado[idx] <= 1'b0;
                end else begin
                    pos_x[idx] <= prox_x;
                    pos_y[idx] <= prox_y;
                end
            end

            if (estado == INSERE && tem_livre) begin
                pos_x[indice_livre]       <= lat_x;
                pos_y[indice_livre]       <= lat_y;
                dir[indice_livre]         <= lat_dir;
                renderizado[indice_livre] <= 1'b1;
            end

            // Last assignment: the kill port overrides the rendered bit.
            if (enable_load_tiro) renderizado[indice_escrita] <= loaded_tiro;
        end
    end

    assign tiro_x           = pos_x[indice_leitura];
    assign tiro_y           = pos_y[indice_leitura];
    assign tiro_renderizado = renderizado[indice_leitura];
    assign ocupado          = (estado != ESPERA);
    assign db_estado        = estado;

endmodule
